// File: rtl/fb_pixel_writer.sv
// CPU-side pixel writer: buffers pixel stores in a FIFO and commits them to the image RAM during blanking.
// Optional solid-colour fill engine enabled by defining FB_FILL_EN.
module fb_pixel_writer #(
   parameter int unsigned PIXEL_COUNT = 307200,
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned COLOR_W     = 9,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter logic [31:0] CTRL_ADDR   = 32'h0000_0FFF,
   parameter int unsigned DEPTH       = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cpu_wEn,
   input  logic [31:0]        cpu_addr,
   input  logic [31:0]        cpu_data,
   input  logic               active,
   output logic               fb_wEn,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               full,
   output logic               busy,
   output logic               overflow
);
   localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               overflow_reg;
   logic               fb_wEn_reg;
   logic [ADDR_W-1:0]  fb_addr_reg;
   logic [COLOR_W-1:0] fb_data_reg;

   logic [31:0]        offset;
   logic               pix_store;
   logic               ctrl_store;
   logic               clr_ovf;
   logic               fill_cmd;
   logic               in_idle;
   logic               pop;
   logic               push;
   logic               drop;
   logic [ENTRY_W-1:0] entry;
   logic               unused_bits;

   assign offset     = cpu_addr - BASE_ADDR;
   assign pix_store  = cpu_wEn && (cpu_addr >= BASE_ADDR) && (offset < PIXEL_COUNT);
   assign ctrl_store = cpu_wEn && (cpu_addr == CTRL_ADDR);
   assign clr_ovf    = ctrl_store && cpu_data[31];
   assign entry      = {offset[ADDR_W-1:0], cpu_data[COLOR_W-1:0]};
   assign unused_bits = ^{offset[31:ADDR_W], cpu_data[30:COLOR_W]};

`ifdef FB_FILL_EN
   typedef enum logic {IDLE, FILL} state_t;
   state_t             state_reg;
   logic [ADDR_W-1:0]  fill_cnt_reg;
   logic [COLOR_W-1:0] color_reg;

   assign fill_cmd = ctrl_store && !cpu_data[31];
   assign in_idle  = (state_reg == IDLE);
   assign busy     = (count_reg != '0) || (state_reg == FILL);
`else
   assign fill_cmd = 1'b0;
   assign in_idle  = 1'b1;
   assign busy     = (count_reg != '0);
`endif

   // A fill command discards queued stores, so nothing is popped that cycle.
   assign pop  = in_idle && !fill_cmd && (count_reg != '0) && !active;
   assign push = pix_store && ((count_reg < CNT_W'(DEPTH)) || pop);
   assign drop = pix_store && !push;

   assign full     = (count_reg == CNT_W'(DEPTH));
   assign overflow = overflow_reg;
   assign fb_wEn   = fb_wEn_reg;
   assign fb_addr  = fb_addr_reg;
   assign fb_data  = fb_data_reg;

   // Storage has no reset so it can map onto RAM; validity is tracked by count_reg.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg] <= entry;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         fb_wEn_reg   <= 1'b0;
         fb_addr_reg  <= '0;
         fb_data_reg  <= '0;
`ifdef FB_FILL_EN
         state_reg    <= IDLE;
         fill_cnt_reg <= '0;
         color_reg    <= '0;
`endif
      end else begin
         fb_wEn_reg <= 1'b0;

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
            fb_wEn_reg  <= 1'b1;
            fb_addr_reg <= mem[rd_ptr_reg][ENTRY_W-1:COLOR_W];
            fb_data_reg <= mem[rd_ptr_reg][COLOR_W-1:0];
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase

         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
         end

`ifdef FB_FILL_EN
         if (fill_cmd) begin
            state_reg    <= FILL;
            fill_cnt_reg <= '0;
            color_reg    <= cpu_data[COLOR_W-1:0];
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
         end else if ((state_reg == FILL) && !active) begin
            fb_wEn_reg  <= 1'b1;
            fb_addr_reg <= fill_cnt_reg;
            fb_data_reg <= color_reg;
            if (fill_cnt_reg == ADDR_W'(PIXEL_COUNT - 1)) begin
               state_reg    <= IDLE;
               fill_cnt_reg <= '0;
            end else begin
               fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: queue-based reference model checked every cycle, plus directed literal checks.
// Fill scenarios run only when FB_FILL_EN is defined.
module tb_fb_pixel_writer;
   localparam int unsigned PC    = 160;
   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam logic [31:0] CTRL  = 32'h0000_0FFF;
`ifdef FB_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_wEn = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_data = '0;
   logic        active = 1'b0;
   logic        fb_wEn;
   logic [19:0] fb_addr;
   logic [8:0]  fb_data;
   logic        full;
   logic        busy;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   fb_pixel_writer #(
      .PIXEL_COUNT(PC), .ADDR_W(20), .COLOR_W(9),
      .BASE_ADDR(BASE), .CTRL_ADDR(CTRL), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr),
      .cpu_data(cpu_data), .active(active), .fb_wEn(fb_wEn), .fb_addr(fb_addr),
      .fb_data(fb_data), .full(full), .busy(busy), .overflow(overflow)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending stores as a queue, outputs derived from the rules directly.
   int   q_addr[$];
   int   q_data[$];
   bit   m_valid = 0;
   bit   m_wen, m_ovf, m_fill;
   int   m_addr, m_data, m_fc, m_color;

   always @(posedge clock) begin
      bit pix, ctrl, fcmd, do_pop;
      if (reset) begin
         q_addr.delete(); q_data.delete();
         m_wen = 0; m_ovf = 0; m_fill = 0; m_addr = 0; m_data = 0; m_fc = 0; m_color = 0;
         m_valid = 1;
      end else begin
         m_wen  = 0;
         pix    = cpu_wEn && cpu_addr >= BASE && cpu_addr < BASE + PC;
         ctrl   = cpu_wEn && cpu_addr == CTRL;
         fcmd   = FILL_EN && ctrl && !cpu_data[31];
         do_pop = !m_fill && !fcmd && q_addr.size() > 0 && !active;
         if (do_pop) begin
            m_wen  = 1;
            m_addr = q_addr.pop_front();
            m_data = q_data.pop_front();
         end
         if (pix) begin
            if (q_addr.size() < DEPTH) begin
               q_addr.push_back(int'(cpu_addr - BASE));
               q_data.push_back(int'(cpu_data[8:0]));
            end else begin
               m_ovf = 1;
            end
         end
         if (ctrl && cpu_data[31]) m_ovf = 0;
         if (fcmd) begin
            q_addr.delete(); q_data.delete();
            m_fill = 1; m_fc = 0; m_color = int'(cpu_data[8:0]);
         end else if (m_fill && !active) begin
            m_wen = 1; m_addr = m_fc; m_data = m_color;
            m_fc++;
            if (m_fc == PC) m_fill = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (m_valid) begin
         chk("model_wEn",  32'(fb_wEn),   32'(m_wen));
         chk("model_addr", 32'(fb_addr),  m_addr);
         chk("model_data", 32'(fb_data),  m_data);
         chk("model_ovf",  32'(overflow), 32'(m_ovf));
         chk("model_full", 32'(full),     32'(q_addr.size() == DEPTH));
         chk("model_busy", 32'(busy),     32'(q_addr.size() != 0 || m_fill));
      end
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      cpu_wEn = 1'b1; cpu_addr = a; cpu_data = d;
      @(negedge clock);
      cpu_wEn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("reset_wEn", 32'(fb_wEn), 0);
      chk("reset_addr", 32'(fb_addr), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_ovf", 32'(overflow), 0);

      // Single store, blanking: visible one cycle after the store edge.
      store(BASE + 5, 3);
      chk("t1_wEn_early", 32'(fb_wEn), 0);
      @(negedge clock);
      chk("t1_wEn", 32'(fb_wEn), 1);
      chk("t1_addr", 32'(fb_addr), 5);
      chk("t1_data", 32'(fb_data), 3);
      $display("[TB] t1 single store done");

      // Fill during active display, overflow, then in-order drain.
      active = 1'b1;
      for (int i = 0; i < 8; i++) store(BASE + i, 16 + i);
      chk("t2_full", 32'(full), 1);
      chk("t2_wEn_held", 32'(fb_wEn), 0);
      store(BASE + 8, 99);
      chk("t2_overflow", 32'(overflow), 1);
      active = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("t2_drain_wEn", 32'(fb_wEn), 1);
         chk("t2_drain_addr", 32'(fb_addr), i);
         chk("t2_drain_data", 32'(fb_data), 16 + i);
      end
      @(negedge clock);
      chk("t2_idle_wEn", 32'(fb_wEn), 0);
      chk("t2_hold_addr", 32'(fb_addr), 7);
      store(CTRL, 32'h8000_0000);
      chk("t6_ovf_clear", 32'(overflow), 0);
      $display("[TB] t2 full/overflow/drain done");

      // Push into a full FIFO on the same cycle as a pop.
      active = 1'b1;
      for (int i = 0; i < 8; i++) store(BASE + i, i);
      chk("t3_full", 32'(full), 1);
      active = 1'b0;
      store(BASE + 20, 5);
      chk("t3_ovf", 32'(overflow), 0);
      chk("t3_first_addr", 32'(fb_addr), 0);
      repeat (8) @(negedge clock);
      chk("t3_last_addr", 32'(fb_addr), 20);
      chk("t3_last_data", 32'(fb_data), 5);
      @(negedge clock);
      chk("t3_busy", 32'(busy), 0);
      $display("[TB] t3 simultaneous push/pop done");

      // Out-of-range addresses are ignored.
      store(BASE + PC, 1);
      chk("t6_oob_busy", 32'(busy), 0);
      store(32'h0, 1);
      chk("t6_zero_busy", 32'(busy), 0);
      store(BASE - 2, 1);
      @(negedge clock);
      chk("t6_wEn", 32'(fb_wEn), 0);
      chk("t6_ovf", 32'(overflow), 0);
      $display("[TB] t6 address decode done");

      // Reset mid-drain discards pending entries.
      active = 1'b1;
      for (int i = 0; i < 4; i++) store(BASE + 30 + i, 1);
      reset = 1'b1; active = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_drain_busy", 32'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("rst_drain_wEn", 32'(fb_wEn), 0);
      end
      $display("[TB] reset mid-drain done");

`ifdef FB_FILL_EN
      begin
         int nfill, nstale;
         bit done;
         active = 1'b1;
         for (int i = 1; i <= 3; i++) store(BASE + i, 4);
         store(CTRL, 9);
         chk("t4_busy", 32'(busy), 1);
         active = 1'b0; nfill = 0; nstale = 0; done = 0;
         for (int c = 0; c < 4 * PC && !done; c++) begin
            if (c == 5) begin
               cpu_wEn = 1'b1; cpu_addr = BASE + 10; cpu_data = 2;
            end else begin
               cpu_wEn = 1'b0;
            end
            active = (c % 3 == 2);
            @(negedge clock);
            if (fb_wEn && fb_data == 9) nfill++;
            if (fb_wEn && fb_data == 4) nstale++;
            if (!busy) done = 1;
         end
         cpu_wEn = 1'b0; active = 1'b0;
         chk("t4_done", 32'(done), 1);
         chk("t4_fill_count", nfill, PC);
         chk("t4_stale", nstale, 0);
         chk("t4_after_wEn", 32'(fb_wEn), 1);
         chk("t4_after_addr", 32'(fb_addr), 10);
         chk("t4_after_data", 32'(fb_data), 2);
         $display("[TB] t4 fill done");

         store(CTRL, 7);
         done = 0;
         for (int c = 0; c < 4 * PC && !done; c++) begin
            @(negedge clock);
            if (fb_wEn && fb_addr == 99) done = 1;
         end
         chk("t5_reached", 32'(done), 1);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         chk("t5_wEn", 32'(fb_wEn), 0);
         chk("t5_busy", 32'(busy), 0);
         nfill = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (fb_wEn) nfill++;
         end
         chk("t5_no_writes", nfill, 0);
         $display("[TB] t5 reset mid-fill done");
      end
`endif

      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
